// File: rtl/pkg_1553.sv
// Shared definitions for the 1553 receive path: buffer entry layout, default sizing,
// gap-timer state encoding and a saturating-increment helper.
package pkg_1553;

    localparam int ENTRY_W        = 19;
    localparam int SOM_BIT        = 18;
    localparam int CSW_BIT        = 17;
    localparam int DW_BIT         = 16;
    localparam int DWORD_LSB      = 0;
    localparam int DWORD_W        = 16;

    localparam int DEF_DEPTH      = 16;
    localparam int DEF_GAP_CYCLES = 32;

    localparam int ERR_CNT_W      = 8;

    typedef enum logic {
        GAP_IDLE   = 1'b0,
        GAP_IN_MSG = 1'b1
    } gap_state_t;

    // Error counters stick at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/gap_timer_1553.sv
// Bus-silence timer: flags start-of-message when a word arrives after at least
// GAP_CYCLES idle cycles (or first word after reset). Used under RXBUF_GAP_DETECT_EN.
module gap_timer_1553
    import pkg_1553::*;
#(
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic dec_clk,
    input  logic rst_n,
    input  logic rx_dval,
    output logic som
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    gap_state_t       state_reg, state_next;
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic [GAP_W-1:0] gap_cnt_inc;

    always_ff @(posedge dec_clk) begin
        if (!rst_n) begin
            state_reg   <= GAP_IDLE;
            gap_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            gap_cnt_reg <= gap_cnt_next;
        end
    end

    // Any word, good or bad, restarts the silence count.
    always_comb begin
        state_next   = state_reg;
        gap_cnt_next = gap_cnt_reg;
        gap_cnt_inc  = gap_cnt_reg + 1'b1;
        if (rx_dval) begin
            state_next   = GAP_IN_MSG;
            gap_cnt_next = '0;
        end else if (state_reg == GAP_IN_MSG) begin
            if (gap_cnt_inc == GAP_W'(GAP_CYCLES)) begin
                state_next   = GAP_IDLE;
                gap_cnt_next = '0;
            end else begin
                gap_cnt_next = gap_cnt_inc;
            end
        end
    end

    always_comb begin
        som = (state_reg == GAP_IDLE);
    end

endmodule

// File: rtl/rx_word_buffer_1553.sv
// Receive word FIFO for a 1553 decoder with parity/overflow counters.
// Define RXBUF_GAP_DETECT_EN to tag start-of-message words via gap_timer_1553.
module rx_word_buffer_1553
    import pkg_1553::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                       dec_clk,
    input  logic                       rst_n,
    input  logic [DWORD_W-1:0]         rx_dword,
    input  logic                       rx_dval,
    input  logic                       rx_csw,
    input  logic                       rx_dw,
    input  logic                       rx_perr,
    input  logic                       clr,
    input  logic                       rd_en,
    output logic [ENTRY_W-1:0]         rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [ERR_CNT_W-1:0]       perr_cnt,
    output logic [ERR_CNT_W-1:0]       ovf_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (DEPTH < 4 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || GAP_CYCLES < 1) begin : g_bad_params
        $error("rx_word_buffer_1553: DEPTH must be a power of two in 4..64, GAP_CYCLES >= 1");
    end

    logic [ENTRY_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg, count_next;
    logic                 full_reg, empty_reg, rd_valid_reg;
    logic [ENTRY_W-1:0]   rd_data_reg, wr_entry;
    logic                 som, good_word, wr_accept, rd_accept;
    logic [1:0]           err_evt;
    logic [1:0][ERR_CNT_W-1:0] err_cnt;

`ifdef RXBUF_GAP_DETECT_EN
    gap_timer_1553 #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_gap_timer (
        .dec_clk (dec_clk),
        .rst_n   (rst_n),
        .rx_dval (rx_dval),
        .som     (som)
    );
`else
    assign som = 1'b0;
`endif

    // A full buffer still takes a word when the same cycle frees a slot.
    always_comb begin
        good_word  = rx_dval & ~rx_perr;
        wr_accept  = ~clr & good_word & (~full_reg | rd_en);
        rd_accept  = ~clr & rd_en & ~empty_reg;
        err_evt[0] = ~clr & rx_dval & rx_perr;
        err_evt[1] = ~clr & good_word & full_reg & ~rd_en;
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (wr_accept && !rd_accept) begin
            count_next = count_reg + 1'b1;
        end else if (rd_accept && !wr_accept) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_comb begin
        wr_entry                         = '0;
        wr_entry[SOM_BIT]                = som;
        wr_entry[CSW_BIT]                = rx_csw;
        wr_entry[DW_BIT]                 = rx_dw;
        wr_entry[DWORD_LSB +: DWORD_W]   = rx_dword;
    end

    always_ff @(posedge dec_clk) begin
        if (rst_n && wr_accept) begin
            mem[wr_ptr_reg] <= wr_entry;
        end
    end

    // Read data comes from the registered RAM port; a same-slot write sees the old entry.
    always_ff @(posedge dec_clk) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            count_reg    <= count_next;
            full_reg     <= (count_next == CNT_W'(DEPTH));
            empty_reg    <= (count_next == '0);
            rd_valid_reg <= rd_accept;
            if (clr) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (wr_accept) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (rd_accept) begin
                    rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                    rd_data_reg <= mem[rd_ptr_reg];
                end
            end
        end
    end

    // Index 0 counts parity drops, index 1 counts overflow drops.
    for (genvar gi = 0; gi < 2; gi++) begin : g_err_cnt
        logic [ERR_CNT_W-1:0] cnt_reg;
        always_ff @(posedge dec_clk) begin
            if (!rst_n || clr) begin
                cnt_reg <= '0;
            end else if (err_evt[gi]) begin
                cnt_reg <= sat_inc(cnt_reg);
            end
        end
        assign err_cnt[gi] = cnt_reg;
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
    assign full     = full_reg;
    assign empty    = empty_reg;
    assign count    = count_reg;
    assign perr_cnt = err_cnt[0];
    assign ovf_cnt  = err_cnt[1];

endmodule

// File: tb/tb_rx_word_buffer_1553.sv
// Bench for rx_word_buffer_1553: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a queue-based model. Honors RXBUF_GAP_DETECT_EN.
module tb_rx_word_buffer_1553;

    localparam int DEPTH = 16;
    localparam int GAP   = 32;
`ifdef RXBUF_GAP_DETECT_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic        dec_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic [15:0] rx_dword = '0;
    logic        rx_dval = 1'b0, rx_csw = 1'b0, rx_dw = 1'b0, rx_perr = 1'b0;
    logic        clr = 1'b0, rd_en = 1'b0;
    logic [18:0] rd_data;
    logic        rd_valid, full, empty;
    logic [4:0]  count;
    logic [7:0]  perr_cnt, ovf_cnt;

    always #5 dec_clk = ~dec_clk;

    rx_word_buffer_1553 #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .dec_clk  (dec_clk),
        .rst_n    (rst_n),
        .rx_dword (rx_dword),
        .rx_dval  (rx_dval),
        .rx_csw   (rx_csw),
        .rx_dw    (rx_dw),
        .rx_perr  (rx_perr),
        .clr      (clr),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .perr_cnt (perr_cnt),
        .ovf_cnt  (ovf_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: a queue of entries plus counters; som from cycles since last word.
    logic [18:0] mq[$];
    int          m_perr = 0, m_ovf = 0, m_sil = 1000000;
    logic        m_rdv = 1'b0;
    logic [18:0] m_rdd = '0;

    always @(posedge dec_clk) begin
        bit rd, wr, was_full, som_m;
        if (!rst_n) begin
            mq.delete();
            m_perr = 0; m_ovf = 0; m_rdv = 1'b0; m_rdd = '0; m_sil = 1000000;
        end else begin
            if (clr) begin
                mq.delete();
                m_perr = 0; m_ovf = 0; m_rdv = 1'b0;
            end else begin
                was_full = (mq.size() == DEPTH);
                rd       = rd_en && (mq.size() > 0);
                wr       = rx_dval && !rx_perr && (!was_full || rd_en);
                som_m    = GAP_EN && (m_sil >= GAP);
                m_rdv    = rd;
                if (rd) m_rdd = mq.pop_front();
                if (wr) mq.push_back({som_m, rx_csw, rx_dw, rx_dword});
                if (rx_dval && rx_perr && m_perr < 255) m_perr++;
                if (rx_dval && !rx_perr && was_full && !rd_en && m_ovf < 255) m_ovf++;
            end
            if (rx_dval) m_sil = 0;
            else if (m_sil < 1000000) m_sil++;
        end
        #1;
        chk("cmp_count",    32'(count),    32'(mq.size()));
        chk("cmp_empty",    32'(empty),    32'(mq.size() == 0));
        chk("cmp_full",     32'(full),     32'(mq.size() == DEPTH));
        chk("cmp_perr_cnt", 32'(perr_cnt), 32'(m_perr));
        chk("cmp_ovf_cnt",  32'(ovf_cnt),  32'(m_ovf));
        chk("cmp_rd_valid", 32'(rd_valid), 32'(m_rdv));
        chk("cmp_rd_data",  32'(rd_data),  32'(m_rdd));
    end

    task automatic cyc(input bit dv = 0, input logic [15:0] w = '0, input bit cs = 0,
                       input bit d = 0, input bit pe = 0, input bit rd = 0,
                       input bit c = 0, input bit rn = 1);
        @(negedge dec_clk);
        rx_dval = dv; rx_dword = w; rx_csw = cs; rx_dw = d; rx_perr = pe;
        rd_en = rd; clr = c; rst_n = rn;
        @(posedge dec_clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(0, '0, 0, 0, 0, 0, 0, 0);
        cyc(0, '0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic read_one(input string name, input logic [18:0] exp);
        cyc(0, '0, 0, 0, 0, 1);
        $display("read %s data=%05h valid=%0b", name, rd_data, rd_valid);
        chk({name, "_valid"}, 32'(rd_valid), 32'd1);
        chk(name, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pdv, prd;
        do_reset();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_perr", 32'(perr_cnt), 32'd0);
        chk("rst_ovf", 32'(ovf_cnt), 32'd0);

        // Three tagged words, ten cycles apart, read back in order.
        cyc(1, 16'h5555, 1, 0);
        repeat (9) cyc();
        cyc(1, 16'hABCD, 1, 0);
        repeat (9) cyc();
        cyc(1, 16'h1234, 0, 1);
        read_one("seq_w0", {GAP_EN, 1'b1, 1'b0, 16'h5555});
        read_one("seq_w1", 19'h2ABCD);
        read_one("seq_w2", 19'h11234);

        // Seventeen words into a sixteen-deep buffer.
        do_reset();
        for (int i = 1; i <= 17; i++) cyc(1, 16'(i), 0, 1);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_cnt", 32'(ovf_cnt), 32'd1);
        for (int i = 1; i <= 16; i++)
            read_one($sformatf("ovf_rd%0d", i), {GAP_EN && (i == 1), 2'b01, 16'(i)});
        chk("ovf_drained_empty", 32'(empty), 32'd1);

        // Full buffer with simultaneous write and read.
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1, 16'h0100 + 16'(i), 1, 0);
        cyc(1, 16'hBEEF, 0, 1, 0, 1);
        chk("fullrw_valid", 32'(rd_valid), 32'd1);
        chk("fullrw_data", 32'(rd_data), 32'({GAP_EN, 2'b10, 16'h0100}));
        chk("fullrw_count", 32'(count), 32'd16);
        chk("fullrw_full", 32'(full), 32'd1);
        chk("fullrw_ovf", 32'(ovf_cnt), 32'd0);
        for (int i = 1; i < 16; i++)
            read_one($sformatf("fullrw_rd%0d", i), {1'b0, 2'b10, 16'h0100 + 16'(i)});
        read_one("fullrw_last", 19'h1BEEF);

        // Parity-error saturation.
        do_reset();
        for (int i = 0; i < 300; i++) cyc(1, 16'($urandom), 1, 0, 1);
        chk("perr_sat", 32'(perr_cnt), 32'd255);
        chk("perr_empty", 32'(empty), 32'd1);

        // Gap detection boundary: 31 idle cycles is inside the message, 32 ends it.
        do_reset();
        cyc(1, 16'h0AAA, 1, 0);
        repeat (31) cyc();
        cyc(1, 16'h0BBB, 0, 1);
        repeat (32) cyc();
        cyc(1, 16'h0CCC, 1, 0);
        read_one("gap_w0", {GAP_EN, 2'b10, 16'h0AAA});
        read_one("gap_w1", {1'b0, 2'b01, 16'h0BBB});
        read_one("gap_w2", {GAP_EN, 2'b10, 16'h0CCC});

        // Clear with a concurrent word while holding five entries.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 16'h0200 + 16'(i), 0, 1);
        cyc(1, 16'h0F0F, 0, 1, 1);
        chk("clr_pre_count", 32'(count), 32'd5);
        chk("clr_pre_perr", 32'(perr_cnt), 32'd1);
        cyc(1, 16'hDEAD, 0, 1, 0, 0, 1);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_empty", 32'(empty), 32'd1);
        chk("clr_perr", 32'(perr_cnt), 32'd0);
        chk("clr_ovf", 32'(ovf_cnt), 32'd0);
        cyc(0, '0, 0, 0, 0, 1);
        chk("clr_no_word", 32'(rd_valid), 32'd0);

        // Randomized traffic in phases: mixed, write-only, read-heavy, sparse.
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            case ((k / 400) % 4)
                0:       begin pdv = 45; prd = 35; end
                1:       begin pdv = 60; prd = 0;  end
                2:       begin pdv = 30; prd = 80; end
                default: begin pdv = 4;  prd = 20; end
            endcase
            cyc($urandom_range(99) < pdv, 16'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(99) < 10, $urandom_range(99) < prd,
                $urandom_range(199) == 0, $urandom_range(499) != 0);
        end
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
